// File: rtl/onewire_write_byte.sv
// rtl/onewire_write_byte.sv - 1-Wire master byte transmitter, eight LSB-first write slots
module onewire_write_byte #(
    parameter int CLKS_PER_US = 27,
    parameter int SLOT_US     = 70,
    parameter int LOW1_US     = 6,
    parameter int LOW0_US     = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       drive_low,
    output logic       done,
    output logic [3:0] bit_idx
);

    localparam int SLOT_CYC = SLOT_US * CLKS_PER_US;
    localparam int CNT_W    = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;

    // Slot timing constants, sized to the counter so every compare is width-matched.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] LOW1_CYC = CNT_W'(LOW1_US * CLKS_PER_US);
    localparam logic [CNT_W-1:0] LOW0_CYC = CNT_W'(LOW0_US * CLKS_PER_US);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SLOT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             drive_low_q, drive_low_d;

    // State and datapath registers; reset wins over any same-edge start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            drive_low_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            drive_low_q <= drive_low_d;
        end
    end

    // Next-state logic; drive_low is computed from next-state values so the
    // registered pin lines up with the counter of the cycle it belongs to.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts start just like IDLE so bytes can run back to back.
                cnt_d     = '0;
                bit_idx_d = '0;
                if (start) begin
                    shreg_d = data;
                    state_d = S_SLOT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SLOT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd7) begin
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The last slot cycle always falls past either low time, so the bus is
        // guaranteed released for at least one cycle between slots.
        drive_low_d = (state_d == S_SLOT) &&
                      (cnt_d < (shreg_d[0] ? LOW1_CYC : LOW0_CYC));
    end

    assign busy      = (state_q == S_SLOT);
    assign done      = (state_q == S_DONE);
    assign bit_idx   = bit_idx_q;
    assign drive_low = drive_low_q;

endmodule

// File: doc/onewire_write_byte.md
# onewire_write_byte

Master-side 1-Wire byte transmitter. It serialises one 8-bit value, LSB first, into eight write time slots on the bus and pairs with the master read-byte block; both share the top module's open-drain pad. The block only requests `drive_low`. The top module turns that into the pad enable, so the bus is released whenever `drive_low` is 0. Timing assumes a 27 MHz clock, with every duration expressed in whole microseconds times `CLKS_PER_US`.

## Interface

Parameters:

- `CLKS_PER_US`, 27, clock cycles per microsecond.
- `SLOT_US`, 70, total write-slot length including recovery.
- `LOW1_US`, 6, low time for a write-1 slot.
- `LOW0_US`, 60, low time for a write-0 slot.

Ports:

- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `start`, input, 1: single-cycle request to transmit `data`.
- `data`, input, 8: byte to send; sampled only in the cycle `start` is accepted.
- `busy`, output, 1: high from the cycle after acceptance through the last slot cycle.
- `drive_low`, output, 1: request to pull the bus low.
- `done`, output, 1: one-cycle pulse after the 8th slot completes.
- `bit_idx`, output, 4: index of the bit currently being sent, 0..7; holds 8 in DONE.

## Operation

- States: IDLE, SLOT, DONE.
- Internal registers:
  - `shreg[7:0]`, the latched byte.
  - `cnt`, sized for `SLOT_US*CLKS_PER_US - 1`, which is 1889 at defaults.
  - `bit_idx`.
- IDLE:
  - All outputs are 0 and `bit_idx` is 0.
  - `start=1` latches `data` into `shreg`, clears `cnt` and `bit_idx`, and moves to SLOT.
- SLOT:
  - Each slot lasts exactly `SLOT_CYC = SLOT_US*CLKS_PER_US` cycles, with `cnt` running 0..SLOT_CYC-1.
  - `drive_low = (cnt < LOWx_CYC)`. `LOWx_CYC` is `LOW1_US*CLKS_PER_US` (162) when `shreg[0]=1`, and `LOW0_US*CLKS_PER_US` (1620) when `shreg[0]=0`.
  - At `cnt = SLOT_CYC-1`: shift `shreg` right, increment `bit_idx`, reset `cnt` to 0.
  - If `bit_idx` was 7 at that point, go to DONE instead.
- DONE:
  - Lasts one cycle, with `done=1`, `busy=0`, `drive_low=0`, `bit_idx=8`.
  - The next state is IDLE.
  - A `start` in this cycle is accepted exactly as in IDLE, which gives back-to-back bytes.
- `start` while in SLOT is ignored. It does not alter `shreg`, and no request is queued.
- Changes to `data` outside the acceptance cycle have no effect.
- `drive_low` is a registered output. It must never be high while in IDLE or DONE, and never high in the last cycle of any slot. That guarantees at least one released cycle between slots.

## Timing

- Reset values: `busy=0`, `drive_low=0`, `done=0`, `bit_idx=0`, state IDLE, `cnt=0`, `shreg=0`.
- `rst` overrides everything in the same edge, including a simultaneous `start` (the `start` is lost).
- `rst` mid-slot releases `drive_low` from the next cycle onward, with no `done` pulse.
- Cycle numbering: `start` accepted at edge T.
  - Cycle T+1: `busy=1`, `cnt=0`, and `drive_low` is high for the slot-0 low phase.
  - Slot k occupies cycles T+1+1890k through T+1890(k+1).
  - The last slot ends at T+15120.
  - `done=1` in cycle T+15121 only.
- Per-slot low length is exact: 162 cycles for a 1, 1620 cycles for a 0.
  - Released remainder is 1728 cycles for a 1, 270 for a 0.
- Latency from `start` to first bus low is 1 cycle. Total byte time is 15120 cycles plus the 1-cycle DONE.
- Width rule: `cnt` is compared with `<` against constants computed at elaboration. No overflow is possible because `cnt` wraps explicitly at SLOT_CYC-1.

## Test plan

- Reset then idle 100 cycles, with `start=0`, → `drive_low`, `busy`, `done` all 0 and `bit_idx=0` throughout.
- `start` with `data=8'hA5` → `drive_low` low-phase lengths in order 162, 1620, 162, 1620, 1620, 162, 1620, 162.
  - Each slot is exactly 1890 cycles.
  - `done` pulses at T+15121 and `busy` falls in that same cycle.
- `data=8'h00` then `8'hFF`, with `start` asserted in the `done` cycle of the first byte → second byte's first low cycle is at T+15122.
  - The second byte shows eight 162-cycle lows.
  - No gap cycle other than the DONE cycle.
- During a `8'h3C` transfer:
  - Toggle `data` to `8'hFF` at cycle T+500 → waveform still matches 8'h3C.
  - Pulse `start` at T+4000 → ignored; exactly one `done` pulse.
- `rst` asserted at cycle T+2000 (slot 1, low phase, `data=8'h00`) → `drive_low=0` from T+2001 onward.
  - `busy=0` and `bit_idx=0`, with no `done`.
  - A subsequent `start` transmits normally.
- `rst` and `start` high in the same cycle → stays IDLE and `busy` remains 0.
